ahb3lite_host: RTL and testbench

//  Single-initiator AHB3-lite master. Turns a valid/ready request stream into NONSEQ SINGLE transfers.

---
 rtl/ahb3lite_pkg.sv | 19 +
 rtl/ahb3lite_if.sv | 27 ++
 rtl/ahb3lite_host.sv | 131 +++++++++++++
 tb/tb_ahb3lite_host.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings and bus widths used by the host and its bench.
package ahb3lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_if.sv
// AHB3-lite single-initiator bus bundle with master and slave views.
interface ahb3lite_if;
  import ahb3lite_pkg::*;

  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb3lite_host.sv
// AHB3-lite master: valid/ready requests become pipelined NONSEQ SINGLE transfers,
// one in-order response per request, with two-cycle ERROR handling.
module ahb3lite_host
  import ahb3lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  ahb3lite_if.master        ahb
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [DATA_W-1:0] wdata;
  } aslot_t;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] wdata;
  } dslot_t;

  aslot_t            a_q, a_d;
  dslot_t            d_q, d_d;
  logic              a_valid_q, a_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              hold_q, hold_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic err1_c, a_adv_c, d_done_c, accept_c;

  // Handshake decode; ready is gated by reset so nothing is taken while RESETn is low.
  always_comb begin
    err1_c    = ahb.HRESP & ~ahb.HREADY;
    a_adv_c   = ahb.HREADY & a_valid_q & ~hold_q;
    d_done_c  = ahb.HREADY & d_valid_q;
    req_ready = RESETn & (~a_valid_q | (ahb.HREADY & ~hold_q & ~err1_c));
    accept_c  = req_valid & req_ready;
  end

  always_comb begin
    a_d       = a_q;
    a_valid_d = a_valid_q;
    d_d       = d_q;
    d_valid_d = d_valid_q;
    hold_d    = hold_q;

    if (a_adv_c) begin
      d_d       = '{write: a_q.write, wdata: a_q.wdata};
      d_valid_d = 1'b1;
      a_valid_d = 1'b0;
    end else if (d_done_c) begin
      d_valid_d = 1'b0;
    end

    if (accept_c) begin
      a_d       = '{addr: req_addr, write: req_write, size: req_size, wdata: req_wdata};
      a_valid_d = 1'b1;
    end

    // First ERROR cycle cancels the pending address phase until the error completes.
    if (err1_c & d_valid_q) begin
      hold_d = 1'b1;
    end else if (ahb.HREADY) begin
      hold_d = 1'b0;
    end

    htrans_d    = (a_valid_d & ~hold_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
    rsp_valid_d = d_done_c;
    rsp_err_d   = d_done_c & (ahb.HRESP == HRESP_ERROR);
    rsp_rdata_d = (d_done_c & ~d_q.write) ? ahb.HRDATA : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      a_q         <= '0;
      d_q         <= '0;
      a_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      hold_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_q         <= a_d;
      d_q         <= d_d;
      a_valid_q   <= a_valid_d;
      d_valid_q   <= d_valid_d;
      hold_q      <= hold_d;
      htrans_q    <= htrans_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ahb.HADDR     = a_q.addr;
  assign ahb.HWRITE    = a_q.write;
  assign ahb.HSIZE     = a_q.size;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = d_q.wdata;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifndef SYNTHESIS
  hresp_without_data_phase: assert property (
    @(posedge CLK) disable iff (!RESETn) ahb.HRESP |-> d_valid_q
  ) else $error("HRESP asserted with no data phase outstanding");
`endif

endmodule

// File: tb/tb_ahb3lite_host.sv
// Directed bench for ahb3lite_host: the bench plays the slave cycle by cycle.
module tb_ahb3lite_host;
  import ahb3lite_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp;
  int n_err;

  ahb3lite_if ahb ();

  ahb3lite_host #(.HPROT_VAL(4'b0011)) dut (
    .CLK       (clk),
    .RESETn    (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ahb       (ahb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic w,
                           input logic [2:0] s, input logic [31:0] d);
    req_valid = v;
    req_addr  = a;
    req_write = w;
    req_size  = s;
    req_wdata = d;
  endtask

  task automatic drive_slv(input logic rdy, input logic resp, input logic [31:0] rd);
    ahb.HREADY = rdy;
    ahb.HRESP  = resp;
    ahb.HRDATA = rd;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_req(1'b1, 32'h0000_0008, 1'b1, HSIZE_WORD, 32'h1234_5678);
    drive_slv(1'b1, 1'b0, 32'h0);

    // 1: reset held three cycles with a request pending
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_htrans", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
    end
    check_eq("rst_haddr", ahb.HADDR, 32'h0);
    check_eq("rst_hwdata", ahb.HWDATA, 32'h0);
    rst_n = 1'b1;
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_htrans", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));

    // 2: back-to-back write then read of 0x4
    drive_req(1'b1, 32'h0000_0004, 1'b1, HSIZE_WORD, 32'hA5A5_1234);
    tick();
    check_eq("b2b_w_htrans", 32'(ahb.HTRANS), 32'(HTRANS_NONSEQ));
    check_eq("b2b_w_haddr", ahb.HADDR, 32'h0000_0004);
    check_eq("b2b_w_hwrite", 32'(ahb.HWRITE), 32'd1);
    check_eq("b2b_w_hsize", 32'(ahb.HSIZE), 32'(HSIZE_WORD));
    check_eq("b2b_hburst", 32'(ahb.HBURST), 32'd0);
    check_eq("b2b_hprot", 32'(ahb.HPROT), 32'h3);
    check_eq("b2b_hmastlock", 32'(ahb.HMASTLOCK), 32'd0);
    drive_req(1'b1, 32'h0000_0004, 1'b0, HSIZE_WORD, 32'h0);
    #1;
    check_eq("b2b_ready_pipe", 32'(req_ready), 32'd1);
    tick();
    check_eq("b2b_r_htrans", 32'(ahb.HTRANS), 32'(HTRANS_NONSEQ));
    check_eq("b2b_r_hwrite", 32'(ahb.HWRITE), 32'd0);
    check_eq("b2b_hwdata", ahb.HWDATA, 32'hA5A5_1234);
    check_eq("b2b_no_rsp_yet", 32'(rsp_valid), 32'd0);
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    drive_slv(1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    check_eq("b2b_w_rsp", 32'(rsp_valid), 32'd1);
    check_eq("b2b_w_err", 32'(rsp_err), 32'd0);
    check_eq("b2b_w_rdata", rsp_rdata, 32'h0);
    check_eq("b2b_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    drive_slv(1'b1, 1'b0, 32'hA5A5_1234);
    tick();
    check_eq("b2b_r_rsp", 32'(rsp_valid), 32'd1);
    check_eq("b2b_r_rdata", rsp_rdata, 32'hA5A5_1234);
    check_eq("b2b_r_err", 32'(rsp_err), 32'd0);
    drive_slv(1'b1, 1'b0, 32'h0);
    tick();
    check_eq("b2b_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 3: three wait states on read 0x10 with write 0x14 queued behind it
    drive_req(1'b1, 32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    drive_req(1'b1, 32'h0000_0014, 1'b1, HSIZE_WORD, 32'h1111_2222);
    tick();
    check_eq("ws_next_haddr", ahb.HADDR, 32'h0000_0014);
    drive_req(1'b1, 32'h0000_0018, 1'b0, HSIZE_WORD, 32'h0);
    drive_slv(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("ws_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ws_haddr", ahb.HADDR, 32'h0000_0014);
      check_eq("ws_htrans", 32'(ahb.HTRANS), 32'(HTRANS_NONSEQ));
      check_eq("ws_hwrite", 32'(ahb.HWRITE), 32'd1);
      check_eq("ws_no_rsp", 32'(rsp_valid), 32'd0);
    end
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    drive_slv(1'b1, 1'b0, 32'hCAFE_0010);
    tick();
    check_eq("ws_rsp", 32'(rsp_valid), 32'd1);
    check_eq("ws_rdata", rsp_rdata, 32'hCAFE_0010);
    check_eq("ws_hwdata", ahb.HWDATA, 32'h1111_2222);
    check_eq("ws_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    drive_slv(1'b1, 1'b0, 32'h0);
    tick();
    check_eq("ws_w_rsp", 32'(rsp_valid), 32'd1);
    check_eq("ws_w_rdata", rsp_rdata, 32'h0);
    tick();
    check_eq("ws_single_rsp", 32'(rsp_valid), 32'd0);

    // 4: ERROR on write 0x20 with read 0x24 already in address phase
    drive_req(1'b1, 32'h0000_0020, 1'b1, HSIZE_WORD, 32'h2020_2020);
    tick();
    drive_req(1'b1, 32'h0000_0024, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    check_eq("err_haddr_pre", ahb.HADDR, 32'h0000_0024);
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    drive_slv(1'b0, 1'b1, 32'h0);
    #1;
    check_eq("err_c1_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("err_c2_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    check_eq("err_c2_haddr", ahb.HADDR, 32'h0000_0024);
    check_eq("err_c2_no_rsp", 32'(rsp_valid), 32'd0);
    drive_slv(1'b1, 1'b1, 32'h0);
    tick();
    check_eq("err_rsp", 32'(rsp_valid), 32'd1);
    check_eq("err_rsp_err", 32'(rsp_err), 32'd1);
    check_eq("err_reissue", 32'(ahb.HTRANS), 32'(HTRANS_NONSEQ));
    check_eq("err_reissue_haddr", ahb.HADDR, 32'h0000_0024);
    drive_slv(1'b1, 1'b0, 32'h0);
    tick();
    check_eq("err_no_dup", 32'(rsp_valid), 32'd0);
    check_eq("err_after_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    drive_slv(1'b1, 1'b0, 32'h2424_2424);
    tick();
    check_eq("err_r_rsp", 32'(rsp_valid), 32'd1);
    check_eq("err_r_err", 32'(rsp_err), 32'd0);
    check_eq("err_r_rdata", rsp_rdata, 32'h2424_2424);
    drive_slv(1'b1, 1'b0, 32'h0);
    tick();

    // 5: BYTE write to 0x101 then HWORD read of 0x102
    drive_req(1'b1, 32'h0000_0101, 1'b1, HSIZE_BYTE, 32'h0000_3300);
    tick();
    check_eq("sz_b_hsize", 32'(ahb.HSIZE), 32'd0);
    check_eq("sz_b_haddr", ahb.HADDR, 32'h0000_0101);
    drive_req(1'b1, 32'h0000_0102, 1'b0, HSIZE_HWORD, 32'h0);
    tick();
    check_eq("sz_b_hwdata", ahb.HWDATA, 32'h0000_3300);
    check_eq("sz_h_hsize", 32'(ahb.HSIZE), 32'd1);
    check_eq("sz_h_haddr", ahb.HADDR, 32'h0000_0102);
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    check_eq("sz_w_rsp", 32'(rsp_valid), 32'd1);
    drive_slv(1'b1, 1'b0, 32'hBEEF_0000);
    tick();
    check_eq("sz_r_rdata", rsp_rdata, 32'hBEEF_0000);
    drive_slv(1'b1, 1'b0, 32'h0);
    tick();

    // 6: reset asserted while a read sits in a wait state
    drive_req(1'b1, 32'h0000_0040, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    drive_req(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    drive_slv(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("rmw_wait_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    check_eq("rmw_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    check_eq("rmw_haddr", ahb.HADDR, 32'h0);
    rst_n = 1'b1;
    drive_slv(1'b1, 1'b0, 32'h4040_4040);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rmw_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("rmw_bus_idle", 32'(ahb.HTRANS), 32'(HTRANS_IDLE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
